// File: rtl/rc4_key_dispatcher_if.sv
// Handshake bundle between the key dispatcher and its decrypt cores.
//   core_start : one-cycle pulse per core, key is valid alongside it
//   core_key   : flat key bus, core i owns [i*KEY_WIDTH +: KEY_WIDTH]
//   core_done  : one-cycle verdict-ready pulse per core
//   core_valid : verdict, meaningful only with core_done
//   core_abort : one-cycle pulse sending every core back to idle
// master = dispatcher side, slave = core side.
interface rc4_key_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int KEY_WIDTH = 22
);
  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_valid;
  logic                           core_abort;

  modport master (output core_start, core_key, core_abort,
                  input  core_done, core_valid);
  modport slave  (input  core_start, core_key, core_abort,
                  output core_done, core_valid);
endinterface

// File: rtl/rc4_key_dispatcher.sv
// Candidate-key dispatcher for the parallel RC4 key search.
// Hands ascending keys 0..KEY_MAX to NUM_CORES cores, one dispatch per cycle
// to the lowest-index idle core, collects verdicts, latches the first
// winning key and stops the search on a hit or when the key space is spent.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : level, starts the search from IDLE
//   cif               : core handshake bundle (master side)
//   busy              : high while dispatching or draining
//   correct_key       : winning key (0 until found)
//   correct_key_found : sticky hit flag
//   exhausted         : sticky "every key tried, no hit" flag
//   keys_tried        : accepted verdict count, saturating at 2^KEY_WIDTH
module rc4_key_dispatcher #(
  parameter int                   NUM_CORES = 2,
  parameter int                   KEY_WIDTH = 22,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = {KEY_WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  rc4_key_dispatcher_if.master cif,
  output logic                 busy,
  output logic [KEY_WIDTH-1:0] correct_key,
  output logic                 correct_key_found,
  output logic                 exhausted,
  output logic [KEY_WIDTH:0]   keys_tried
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FOUND, EXHAUSTED} state_t;

  localparam logic [KEY_WIDTH+1:0] KT_SAT = {2'b01, {KEY_WIDTH{1'b0}}};

  state_t                 state, state_nxt;
  // One spare bit so the counter can never wrap back onto key 0.
  logic [KEY_WIDTH:0]     next_key;
  logic [NUM_CORES-1:0]   busy_flag;
  logic [KEY_WIDTH-1:0]   key_q [NUM_CORES];
  logic                   abort_q;

  logic [NUM_CORES-1:0]   accept, hit, free_oh, disp;
  logic                   found_now, dispatch_en, last;
  logic [KEY_WIDTH-1:0]   win_key;
  logic [3:0]             n_acc;
  logic [KEY_WIDTH+1:0]   kt_sum;
  logic [KEY_WIDTH:0]     kt_nxt;

  // Verdicts count only from cores we actually dispatched to, and only
  // while the search is live.
  always_comb begin
    accept  = cif.core_done & busy_flag &
              {NUM_CORES{(state == RUN) || (state == DRAIN)}};
    hit     = accept & cif.core_valid;
    win_key = '0;
    free_oh = '0;
    n_acc   = '0;
    // Descending scan so the lowest index is the one left standing.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) win_key = key_q[i];
      if (!busy_flag[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) n_acc = n_acc + 4'(accept[i]);
    found_now   = |hit;
    last        = (next_key == {1'b0, KEY_MAX});
    // A hit this cycle suppresses dispatch: nothing new starts once found.
    dispatch_en = (state == RUN) && !found_now;
    disp        = free_oh & {NUM_CORES{dispatch_en}};
    kt_sum      = {1'b0, keys_tried} + (KEY_WIDTH+2)'(n_acc);
    kt_nxt      = (kt_sum > KT_SAT) ? KT_SAT[KEY_WIDTH:0] : kt_sum[KEY_WIDTH:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (found_now)          state_nxt = FOUND;
        else if (|disp && last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (found_now)          state_nxt = FOUND;
        else if (busy_flag == '0) state_nxt = EXHAUSTED;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      next_key          <= '0;
      busy_flag         <= '0;
      abort_q           <= 1'b0;
      correct_key       <= '0;
      correct_key_found <= 1'b0;
      exhausted         <= 1'b0;
      keys_tried        <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
    end else begin
      state      <= state_nxt;
      abort_q    <= found_now;
      keys_tried <= kt_nxt;
      if (found_now) busy_flag <= '0;
      else           busy_flag <= (busy_flag & ~accept) | disp;
      if (|disp) next_key <= next_key + 1'b1;
      for (int i = 0; i < NUM_CORES; i++)
        if (disp[i]) key_q[i] <= next_key[KEY_WIDTH-1:0];
      if (found_now) begin
        correct_key       <= win_key;
        correct_key_found <= 1'b1;
      end
      if (state == DRAIN && state_nxt == EXHAUSTED) exhausted <= 1'b1;
    end
  end

  // The key is muxed straight onto the bus in the dispatch cycle so a core
  // can latch it together with core_start; afterwards the register holds it.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign cif.core_key[g*KEY_WIDTH +: KEY_WIDTH] =
      disp[g] ? next_key[KEY_WIDTH-1:0] : key_q[g];
  end

  assign cif.core_start = disp;
  assign cif.core_abort = abort_q;
  assign busy           = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
module tb_rc4_key_dispatcher;
  localparam int KW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: two cores, keys 0..7.
  logic          rst_a, start_a, busy_a, found_a, exh_a;
  logic [KW-1:0] ck_a;
  logic [KW:0]   kt_a;
  rc4_key_dispatcher_if #(.NUM_CORES(2), .KEY_WIDTH(KW)) ifa();
  rc4_key_dispatcher #(.NUM_CORES(2), .KEY_WIDTH(KW), .KEY_MAX(22'd7)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .cif(ifa), .busy(busy_a),
    .correct_key(ck_a), .correct_key_found(found_a), .exhausted(exh_a),
    .keys_tried(kt_a));

  // Instance B: one core, single key 0.
  logic          rst_b, start_b, busy_b, found_b, exh_b;
  logic [KW-1:0] ck_b;
  logic [KW:0]   kt_b;
  rc4_key_dispatcher_if #(.NUM_CORES(1), .KEY_WIDTH(KW)) ifb();
  rc4_key_dispatcher #(.NUM_CORES(1), .KEY_WIDTH(KW), .KEY_MAX(22'd0)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .cif(ifb), .busy(busy_b),
    .correct_key(ck_b), .correct_key_found(found_b), .exhausted(exh_b),
    .keys_tried(kt_b));

  logic b_done, b_valid;
  assign ifb.core_done  = b_done;
  assign ifb.core_valid = b_valid;

  // Core model for A: answers 10 cycles after start; manual pulses OR in.
  logic [1:0]    r_done, r_valid, m_done, m_valid;
  logic          resp_en;
  logic [KW:0]   valid_key;
  int            cnt [2];
  logic [KW-1:0] hk [2];
  logic [KW-1:0] lg_key [256];
  int            lg_core [256];
  int            lg_n = 0;
  int            aborts = 0;
  int            b_starts = 0;

  assign ifa.core_done  = r_done | m_done;
  assign ifa.core_valid = r_valid | m_valid;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_done  <= '0;
      r_valid <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= 0;
    end else begin
      r_done  <= '0;
      r_valid <= '0;
      if (ifa.core_abort) aborts <= aborts + 1;
      for (int i = 0; i < 2; i++) begin
        if (ifa.core_start[i]) begin
          if (lg_n < 256) begin
            lg_key[lg_n]  <= ifa.core_key[i*KW +: KW];
            lg_core[lg_n] <= i;
            lg_n          <= lg_n + 1;
          end
          if (resp_en) begin
            cnt[i] <= 10;
            hk[i]  <= ifa.core_key[i*KW +: KW];
          end
        end else if (ifa.core_abort) cnt[i] <= 0;
        else if (cnt[i] > 1) cnt[i] <= cnt[i] - 1;
        else if (cnt[i] == 1) begin
          cnt[i]     <= 0;
          r_done[i]  <= 1'b1;
          r_valid[i] <= ({1'b0, hk[i]} == valid_key);
        end
      end
    end
  end

  always @(posedge clk)
    if (!rst_b && ifb.core_start[0]) b_starts <= b_starts + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int base, ab0;

  initial begin
    rst_a = 1; rst_b = 1; start_a = 0; start_b = 0;
    m_done = '0; m_valid = '0; b_done = 0; b_valid = 0;
    resp_en = 1; valid_key = '1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_kt", kt_a, 0);
    chk("rst_found", found_a, 0);
    chk("rst_exh", exh_a, 0);
    chk("rst_ck", ck_a, 0);
    chk("rst_start", ifa.core_start, 0);
    chk("rst_abort", ifa.core_abort, 0);

    // 1: no valid verdict, exhaust keys 0..7
    base = lg_n; ab0 = aborts;
    rst_a = 0; start_a = 1;
    for (int k = 0; k < 300 && !exh_a; k++) @(negedge clk);
    chk("t1_exhausted", exh_a, 1);
    chk("t1_ndisp", lg_n - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_key", lg_key[base+i], i);
      chk("t1_core", lg_core[base+i], i % 2);
    end
    chk("t1_kt", kt_a, 8);
    chk("t1_found", found_a, 0);
    chk("t1_ck", ck_a, 0);
    chk("t1_busy", busy_a, 0);
    chk("t1_aborts", aborts - ab0, 0);

    // 2: key 5 is the winner
    rst_a = 1; valid_key = 23'd5;
    @(negedge clk);
    base = lg_n; ab0 = aborts;
    rst_a = 0;
    for (int k = 0; k < 300 && !found_a; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t2_found", found_a, 1);
    chk("t2_ck", ck_a, 5);
    chk("t2_kt", kt_a, 6);
    chk("t2_ndisp", lg_n - base, 6);
    chk("t2_aborts", aborts - ab0, 1);
    chk("t2_busy", busy_a, 0);
    m_done = 2'b11;
    @(negedge clk);
    m_done = 2'b00;
    @(negedge clk);
    chk("t2_kt_after", kt_a, 6);
    chk("t2_ndisp_after", lg_n - base, 6);

    // 3 + 6: manual verdicts, spurious done on idle core1, tie on keys 2/3
    rst_a = 1; resp_en = 0; valid_key = '1;
    @(negedge clk);
    ab0 = aborts;
    rst_a = 0;
    repeat (3) @(negedge clk);
    chk("t3_key0", ifa.core_key[0 +: KW], 0);
    chk("t3_key1", ifa.core_key[KW +: KW], 1);
    m_done = 2'b11; m_valid = 2'b00;
    @(negedge clk);
    chk("t3_kt2", kt_a, 2);
    m_done = 2'b10; m_valid = 2'b10;
    @(negedge clk);
    m_done = 2'b00; m_valid = 2'b00;
    chk("t6_kt", kt_a, 2);
    chk("t6_found", found_a, 0);
    chk("t6_busy", busy_a, 1);
    chk("t6_start1", ifa.core_start, 2'b10);
    chk("t6_key1", ifa.core_key[KW +: KW], 3);
    @(negedge clk);
    chk("t3_slice0", ifa.core_key[0 +: KW], 2);
    chk("t3_slice1", ifa.core_key[KW +: KW], 3);
    m_done = 2'b11; m_valid = 2'b11;
    @(negedge clk);
    m_done = 2'b00; m_valid = 2'b00;
    chk("t3_ck", ck_a, 2);
    chk("t3_found", found_a, 1);
    chk("t3_kt", kt_a, 4);
    @(negedge clk);
    chk("t3_aborts", aborts - ab0, 1);

    // 4: reset after three dispatches, then restart from key 0
    rst_a = 1; resp_en = 1;
    @(negedge clk);
    base = lg_n;
    rst_a = 0;
    for (int k = 0; k < 100 && (lg_n - base) < 3; k++) @(negedge clk);
    chk("t4_ndisp", lg_n - base, 3);
    ab0 = aborts;
    rst_a = 1;
    #1;
    chk("t4_busy", busy_a, 0);
    chk("t4_kt", kt_a, 0);
    chk("t4_start", ifa.core_start, 0);
    chk("t4_key", ifa.core_key, 0);
    chk("t4_found", found_a, 0);
    chk("t4_ck", ck_a, 0);
    @(negedge clk);
    base = lg_n;
    rst_a = 0;
    for (int k = 0; k < 20 && (lg_n - base) < 1; k++) @(negedge clk);
    chk("t4_restart_n", lg_n - base, 1);
    chk("t4_restart_key", lg_key[base], 0);
    chk("t4_restart_core", lg_core[base], 0);
    chk("t4_no_abort", aborts - ab0, 0);

    // 5: one core, KEY_MAX = 0
    rst_b = 0; start_b = 1;
    @(negedge clk);
    chk("t5_start", ifb.core_start, 1);
    chk("t5_key", ifb.core_key, 0);
    @(negedge clk);
    chk("t5_start_off", ifb.core_start, 0);
    chk("t5_busy", busy_b, 1);
    repeat (3) @(negedge clk);
    b_done = 1; b_valid = 0;
    @(negedge clk);
    b_done = 0;
    repeat (2) @(negedge clk);
    chk("t5_exh", exh_b, 1);
    chk("t5_kt", kt_b, 1);
    chk("t5_found", found_b, 0);
    chk("t5_busy_end", busy_b, 0);
    chk("t5_starts", b_starts, 1);
    chk("t5_ck", ck_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rc4_key_dispatcher.md
Name: rc4_key_dispatcher

Overview:
- Upstream work distributor for the parallel RC4 brute-force search.
- Owns the candidate-key counter and hands unique 22-bit keys to NUM_CORES decrypt cores (init/shuffle/decrypt pipelines) over a start/done handshake.
- Collects each core's pass/fail verdict and reports the first correct key to the top level (HEX display, LED).
- Stops all cores once a key is found or the key space is exhausted.

Parameters:
- NUM_CORES, 2, number of attached decrypt cores (1..8).
- KEY_WIDTH, 22, candidate key width in bits.
- KEY_MAX, 22'h3FFFFF, last key to try, inclusive.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level; search begins while high in IDLE.
- core_start  output  NUM_CORES  one-cycle pulse per core; the core latches its key on this pulse.
- core_key  output  NUM_CORES*KEY_WIDTH  key for core i in slice [i*KEY_WIDTH +: KEY_WIDTH]; held stable while core i is busy.
- core_done  input  NUM_CORES  one-cycle pulse from core i: verdict ready.
- core_valid  input  NUM_CORES  core i verdict, sampled only with core_done[i]; 1 = all decrypted bytes printable.
- core_abort  output  1  one-cycle pulse; all cores return to idle.
- busy  output  1  high in RUN and DRAIN.
- correct_key  output  KEY_WIDTH  winning key; 0 until found.
- correct_key_found  output  1  sticky high once found.
- exhausted  output  1  sticky high when KEY_MAX has been tried with no match.
- keys_tried  output  KEY_WIDTH+1  count of verdicts received.

Behaviour:
Reset:
- On reset assertion, every output and internal register returns to 0 immediately: next_key=0, core busy flags=0, core_key slices=0.
- FSM goes to IDLE.
- Reset mid-search abandons the search; no core_abort pulse is emitted.

FSM states: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.

IDLE:
- start=1 → RUN on the next edge.
- start=0 → stay in IDLE.

RUN (dispatch):
- Each cycle, the lowest-index core with busy_flag=0 is given next_key:
  - core_start[i]=1 for one cycle.
  - core_key slice i is loaded with next_key on the same edge.
  - busy_flag[i] is set.
  - next_key increments.
- At most one dispatch per cycle.
- The first dispatch occurs on the first RUN cycle, so core_start[0] is high in the cycle after start is sampled.
- A core whose core_done arrives in cycle t may be redispatched in cycle t+1, not in cycle t.
- When next_key == KEY_MAX is dispatched, no further dispatch occurs. next_key must not wrap; use a KEY_WIDTH+1 internal counter or a last flag. FSM → DRAIN.

Verdict handling (RUN and DRAIN):
- For each core_done[i] pulse: clear busy_flag[i] and increment keys_tried.
- If core_valid[i]=1:
  - correct_key ← core_key slice i.
  - correct_key_found ← 1.
  - core_abort pulses in the next cycle.
  - FSM → FOUND.
- Simultaneous valid verdicts: the lowest core index wins.
- core_done on a core with busy_flag=0 is ignored; keys_tried is unchanged.

DRAIN:
- No dispatch.
- When all busy flags are 0 with no valid verdict: exhausted ← 1, FSM → EXHAUSTED.
- A valid verdict in DRAIN goes to FOUND as above.

FOUND / EXHAUSTED:
- Terminal states; leave only on reset. start is ignored.
- In FOUND, core_done pulses are ignored (no keys_tried change).
- busy = 0.

Widths and ordering:
- Keys are issued in strictly ascending order from 0, each exactly once.
- keys_tried saturates at 2^KEY_WIDTH.

Test Plan:
1. NUM_CORES=2, KEY_MAX=7; core model responds done 10 cycles after start, always valid=0 → keys 0..7 each issued once, in ascending order, alternating core0/core1; exhausted=1; keys_tried=8; correct_key_found=0; no core_abort.
2. Same setup; core model returns valid=1 for key 5 → correct_key=5, correct_key_found=1, one core_abort pulse, no dispatch after FOUND; later done pulses do not change keys_tried.
3. Both cores return done+valid in the same cycle, holding keys 2 (core0) and 3 (core1) → correct_key=2.
4. Assert start; after 3 dispatches, pulse reset mid-search → all outputs 0 within the reset cycle, FSM in IDLE; re-run from start restarts at key 0.
5. NUM_CORES=1, KEY_MAX=0, valid=0 → exactly one core_start, with key 0; exhausted=1; keys_tried=1; next_key does not wrap and no second dispatch occurs.
6. Spurious core_done[1] while core1 is idle → ignored: keys_tried and busy flags unchanged, no FSM transition.
